event_tick_gen: RTL
===================

EVENT_TICK_GEN -- requirements
Module: event_tick_gen

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth (legal range 2..4).
REQ-002 The block SHALL have parameter DEBOUNCE_WIDTH, default 8, meaning the width of DEBOUNCE_LEN and of the qualification counter.
REQ-003 The block SHALL have parameter EDGE_MODE, default 0, meaning the edge that produces TICK: 0 = rising, 1 = falling, 2 = both.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 ACLK  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-006 ARESET  input  1  asynchronous, active-high reset.
REQ-007 ENABLE  input  1  qualification enable; when low, no TICK or GLITCH is produced.
REQ-008 EVENT_IN  input  1  raw event line, asynchronous to ACLK, possibly bouncing.
REQ-009 DEBOUNCE_LEN  input  DEBOUNCE_WIDTH  number of additional stable cycles required after entering qualification.
REQ-010 TICK  output  1  single-cycle registered pulse on each qualified edge selected by EDGE_MODE; this is the event_counter TICK source.
REQ-011 LEVEL  output  1  debounced, registered level of EVENT_IN.
REQ-012 GLITCH  output  1  single-cycle registered pulse when a qualification is aborted.

Function
REQ-013 EVENT_IN SHALL pass through SYNC_STAGES flops; only the last stage (sync_out) SHALL be used by downstream logic.
REQ-014 The FSM SHALL have exactly four states: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
REQ-015 In STABLE_LO with ENABLE=1 and sync_out=1, the FSM SHALL go to QUAL_HI, clear the counter to 0 and latch DEBOUNCE_LEN; STABLE_HI with sync_out=0 SHALL go to QUAL_LO symmetrically.
REQ-016 In a QUAL state, while sync_out equals the candidate level: if counter equals the latched length, the FSM SHALL commit (go to the matching STABLE state, update LEVEL, register TICK per EDGE_MODE); otherwise it SHALL increment the counter.
REQ-017 In a QUAL state, if sync_out reverts to the prior level, the FSM SHALL return to the prior STABLE state, leave LEVEL unchanged, register GLITCH=1 and register TICK=0.
REQ-018 Latency: with EVENT_IN changed and held before ACLK edge 1, TICK SHALL be high in the cycle following edge SYNC_STAGES+DEBOUNCE_LEN+2; LEVEL SHALL change on the same edge.
REQ-019 TICK and GLITCH SHALL each be high for exactly one cycle per event and SHALL never be high in the same cycle.
REQ-020 A DEBOUNCE_LEN of 0 SHALL commit on the first QUAL cycle; the all-ones value SHALL work with no counter wrap (a counter of DEBOUNCE_WIDTH bits is sufficient because comparison precedes increment).
REQ-021 A change of DEBOUNCE_LEN during qualification SHALL NOT affect the qualification in progress; it SHALL take effect at the next QUAL entry.
REQ-022 ENABLE=0 SHALL force the FSM to the STABLE state matching LEVEL, clear the counter, and hold TICK=GLITCH=0 from the next edge; the synchronizer SHALL keep running.
REQ-023 When ENABLE rises with sync_out≠LEVEL, a fresh qualification SHALL start on that edge.
REQ-024 When EDGE_MODE selects no TICK for a committed edge, LEVEL SHALL still update.

Reset
REQ-025 ARESET=1 SHALL asynchronously clear all synchronizer flops, the counter, the latched length, TICK=0, GLITCH=0 and LEVEL=0, and SHALL set the state to STABLE_LO.
REQ-026 Reset asserted mid-qualification SHALL abort without a GLITCH pulse.
REQ-027 EVENT_IN held high through reset release SHALL qualify as a rising edge normally.

Structure
REQ-028 The state encoding and the EDGE_MODE constants (EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2) SHALL reside in the shared package event_pkg.
REQ-029 The synchronizer SHALL be the sub-module sync_ff (parameter STAGES, asynchronous active-high clear); the FSM and counter SHALL stay in event_tick_gen.

Verification
REQ-030 The bench SHALL cover: SYNC_STAGES=2, DEBOUNCE_LEN=3, EDGE_MODE=0, EVENT_IN 0→1 held -> TICK high in the cycle after edge 7 only, LEVEL=1 from then, GLITCH never high.
REQ-031 The bench SHALL cover: DEBOUNCE_LEN=5, EVENT_IN high for 3 cycles then low -> GLITCH one pulse, TICK=0, LEVEL stays 0.
REQ-032 The bench SHALL cover: EDGE_MODE=2, a clean 0→1→0 with each level held 20 cycles -> exactly two TICKs; EDGE_MODE=1 -> exactly one TICK, on the fall.
REQ-033 The bench SHALL cover: DEBOUNCE_LEN=0 and DEBOUNCE_LEN=255 -> TICK at edges 4 and 259 respectively, with no early commit.
REQ-034 The bench SHALL cover: ENABLE dropped mid-QUAL_HI with EVENT_IN still high -> no TICK or GLITCH; ENABLE re-raised -> TICK after a full DEBOUNCE_LEN+1 cycles.
REQ-035 The bench SHALL cover: ARESET pulsed mid-qualification -> all outputs 0 immediately (asynchronously), no GLITCH; with EVENT_IN high after release -> one TICK at SYNC_STAGES+DEBOUNCE_LEN+2.

Source files
------------

// File: rtl/event_pkg.sv
// Shared types and constants for the event tick generator: FSM state encoding
// and the EDGE_MODE selector values.
package event_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } state_t;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // True when a committed edge of the given direction should emit TICK.
  function automatic logic tick_on_commit(input int mode, input logic rising);
    return (mode == EDGE_BOTH) || (rising ? (mode == EDGE_RISE) : (mode == EDGE_FALL));
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; q is the last stage.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: non-blocking assignment so each stage captures the previous stage's
  // value from before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/event_tick_gen.sv
// Debounces an asynchronous event line and emits a one-cycle TICK on each
// qualified edge selected by EDGE_MODE, or GLITCH when qualification aborts.
module event_tick_gen
  import event_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_WIDTH = 8,
  parameter int EDGE_MODE      = 0
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      ENABLE,
  input  logic                      EVENT_IN,
  input  logic [DEBOUNCE_WIDTH-1:0] DEBOUNCE_LEN,
  output logic                      TICK,
  output logic                      LEVEL,
  output logic                      GLITCH
);

  logic sync_out;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (ACLK),
    .rst (ARESET),
    .d   (EVENT_IN),
    .q   (sync_out)
  );

  state_t                    state_q, state_d;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
  logic [DEBOUNCE_WIDTH-1:0] len_q, len_d;
  logic                      level_q, level_d;
  logic                      tick_q, tick_d;
  logic                      glitch_q, glitch_d;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      len_q    <= '0;
      level_q  <= 1'b0;
      tick_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      level_q  <= level_d;
      tick_q   <= tick_d;
      glitch_q <= glitch_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    level_d  = level_q;
    tick_d   = 1'b0;
    glitch_d = 1'b0;

    if (!ENABLE) begin
      state_d = level_q ? STABLE_HI : STABLE_LO;
      cnt_d   = '0;
    end else begin
      case (state_q)
        STABLE_LO: if (sync_out) begin
          state_d = QUAL_HI;
          cnt_d   = '0;
          len_d   = DEBOUNCE_LEN;
        end
        STABLE_HI: if (!sync_out) begin
          state_d = QUAL_LO;
          cnt_d   = '0;
          len_d   = DEBOUNCE_LEN;
        end
        // Compare before increment so an all-ones length never wraps the counter.
        QUAL_HI: begin
          if (sync_out) begin
            if (cnt_q == len_q) begin
              state_d = STABLE_HI;
              level_d = 1'b1;
              tick_d  = tick_on_commit(EDGE_MODE, 1'b1);
            end else begin
              cnt_d = cnt_q + DEBOUNCE_WIDTH'(1);
            end
          end else begin
            state_d  = STABLE_LO;
            glitch_d = 1'b1;
          end
        end
        QUAL_LO: begin
          if (!sync_out) begin
            if (cnt_q == len_q) begin
              state_d = STABLE_LO;
              level_d = 1'b0;
              tick_d  = tick_on_commit(EDGE_MODE, 1'b0);
            end else begin
              cnt_d = cnt_q + DEBOUNCE_WIDTH'(1);
            end
          end else begin
            state_d  = STABLE_HI;
            glitch_d = 1'b1;
          end
        end
        default: state_d = STABLE_LO;
      endcase
    end
  end

  assign TICK   = tick_q;
  assign LEVEL  = level_q;
  assign GLITCH = glitch_q;

endmodule
